// File: rtl/an_scan_monitor_pkg.sv
// Shared constants and types for the 7-segment display bus monitor and related checkers.
package an_scan_monitor_pkg;

  localparam int unsigned DIGITS = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned SEG_W  = 8;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  localparam logic [DIGITS-1:0] AN_BLANK = 8'hFF;
  localparam logic [SEG_W-1:0]  SEG_OFF  = 8'hFF;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  typedef struct packed {
    logic [DIGITS-1:0] an;
    logic [SEG_W-1:0]  seg;
  } sample_t;

endpackage

// File: rtl/an_onehot_dec.sv
// Decodes an active-low anode vector into a digit index plus one-hot / none / multi flags.
module an_onehot_dec
  import an_scan_monitor_pkg::*;
(
  input  logic [DIGITS-1:0] an_n,
  output logic [IDX_W-1:0]  idx_c,
  output logic              one_hot_c,
  output logic              none_c,
  output logic              multi_c
);

  logic [3:0] zeros;

  // Lowest active anode wins the index; the zero count classifies the pattern.
  always_comb begin
    idx_c = '0;
    zeros = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (!an_n[i]) begin
        idx_c = IDX_W'(i);
        zeros = zeros + 4'd1;
      end
    end
  end

  assign one_hot_c = (zeros == 4'd1);
  assign none_c    = (zeros == 4'd0);
  assign multi_c   = (zeros > 4'd1);

endmodule

// File: rtl/an_scan_monitor.sv
// Display-bus reader: settles, decodes and rebuilds the 8-digit frame, flags scan errors.
// Define AN_SCAN_SYNC_EN to add a 2-flop synchronizer on an_in/seg_in.
module an_scan_monitor
  import an_scan_monitor_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned FRAME_TIMEOUT = 1_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DIGITS-1:0]         an_in,
  input  logic [SEG_W-1:0]          seg_in,
  output logic [IDX_W-1:0]          digit_idx,
  output logic                      digit_valid,
  output logic [DIGITS*SEG_W-1:0]   frame_seg,
  output logic                      frame_done,
  output logic                      multi_err,
  output logic                      order_err,
  output logic                      timeout_err
);

  localparam int unsigned CW = 8;
  localparam int unsigned TW = 24;
  localparam sample_t IDLE = '{an: AN_BLANK, seg: SEG_OFF};

  sample_t din_c, s_q, p_q;

`ifdef AN_SCAN_SYNC_EN
  sample_t sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= IDLE;
      sync2_q <= IDLE;
    end else begin
      sync1_q <= '{an: an_in, seg: seg_in};
      sync2_q <= sync1_q;
    end
  end

  assign din_c = sync2_q;
`else
  assign din_c = '{an: an_in, seg: seg_in};
`endif

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IDX_W-1:0]          exp_q, exp_d;
  logic [DIGITS-1:0]         seen_q, seen_d;
  logic [TW-1:0]             tcnt_q, tcnt_d;
  logic [IDX_W-1:0]          idx_d;
  logic [DIGITS*SEG_W-1:0]   frame_d;
  logic                      valid_d, done_d, multi_d, order_d, tout_d;
  logic                      same_c, capture_c;

  logic [IDX_W-1:0] dec_idx_c;
  logic             dec_one_hot_c, dec_none_c, dec_multi_c;

  an_onehot_dec u_dec (
    .an_n      (s_q.an),
    .idx_c     (dec_idx_c),
    .one_hot_c (dec_one_hot_c),
    .none_c    (dec_none_c),
    .multi_c   (dec_multi_c)
  );

  assign same_c = (s_q == p_q);

  // Next-state, capture bookkeeping and timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    seen_d    = seen_q;
    tcnt_d    = tcnt_q;
    idx_d     = digit_idx;
    frame_d   = frame_seg;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    multi_d   = 1'b0;
    order_d   = 1'b0;
    tout_d    = timeout_err;
    capture_c = 1'b0;

    if (!same_c) begin
      cnt_d   = '0;
      state_d = ST_WAIT;
    end else if (cnt_q < CW'(SETTLE_CYCLES)) begin
      cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      ST_WAIT: begin
        if (same_c && cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          if (dec_none_c) begin
            state_d = ST_WAIT;
          end else if (dec_one_hot_c) begin
            capture_c = 1'b1;
            state_d   = ST_HOLD;
          end else if (dec_multi_c) begin
            multi_d = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      default: ;
    endcase

    if (capture_c) begin
      valid_d = 1'b1;
      idx_d   = dec_idx_c;
      frame_d[{dec_idx_c, 3'b000} +: SEG_W] = ~s_q.seg;
      tcnt_d  = '0;
      tout_d  = 1'b0;
      exp_d   = dec_idx_c + IDX_W'(1);
      if (dec_idx_c != exp_q) begin
        order_d = 1'b1;
        seen_d  = DIGITS'(1) << dec_idx_c;
      end else if (dec_idx_c == IDX_W'(DIGITS - 1) && (&seen_q[DIGITS-2:0])) begin
        done_d = 1'b1;
        seen_d = '0;
      end else begin
        seen_d[dec_idx_c] = 1'b1;
      end
    end else begin
      if (tcnt_q < TW'(FRAME_TIMEOUT)) tcnt_d = tcnt_q + TW'(1);
      if (tcnt_d == TW'(FRAME_TIMEOUT)) tout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= IDLE;
      p_q         <= IDLE;
      state_q     <= ST_WAIT;
      cnt_q       <= '0;
      exp_q       <= '0;
      seen_q      <= '0;
      tcnt_q      <= '0;
      digit_idx   <= '0;
      digit_valid <= 1'b0;
      frame_seg   <= '0;
      frame_done  <= 1'b0;
      multi_err   <= 1'b0;
      order_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      s_q         <= din_c;
      p_q         <= s_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      seen_q      <= seen_d;
      tcnt_q      <= tcnt_d;
      digit_idx   <= idx_d;
      digit_valid <= valid_d;
      frame_seg   <= frame_d;
      frame_done  <= done_d;
      multi_err   <= multi_d;
      order_err   <= order_d;
      timeout_err <= tout_d;
    end
  end

endmodule

// File: tb/tb_an_scan_monitor.sv
// Bench for an_scan_monitor: directed vector table, corner sequences, random scan vs reference model.
module tb_an_scan_monitor;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned FT     = 100;
`ifdef AN_SCAN_SYNC_EN
  localparam int unsigned DLY = 3;
`else
  localparam int unsigned DLY = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  an_in, seg_in;
  logic [2:0]  digit_idx;
  logic        digit_valid, frame_done, multi_err, order_err, timeout_err;
  logic [63:0] frame_seg;

  always #5 clk = ~clk;

  an_scan_monitor #(.SETTLE_CYCLES(SETTLE), .FRAME_TIMEOUT(FT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an_in       (an_in),
    .seg_in      (seg_in),
    .digit_idx   (digit_idx),
    .digit_valid (digit_valid),
    .frame_seg   (frame_seg),
    .frame_done  (frame_done),
    .multi_err   (multi_err),
    .order_err   (order_err),
    .timeout_err (timeout_err)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: a pattern event happens once its input run lasts SETTLE+1 edges.
  typedef struct {
    int         kind;   // 0 none, 1 capture, 2 multi
    int         idx;
    logic [7:0] seg;
  } ev_t;

  ev_t        pipe [DLY];
  logic [15:0] last_in;
  int         run;
  int         expect_idx;
  bit         seen [8];
  logic [7:0] m_frame [8];
  int         idle;
  logic [2:0] e_idx;
  logic       e_valid, e_done, e_multi, e_order, e_tout;

  function automatic int zero_count(input logic [7:0] an);
    int n = 0;
    for (int i = 0; i < 8; i++) if (!an[i]) n++;
    return n;
  endfunction

  function automatic int low_zero(input logic [7:0] an);
    for (int i = 0; i < 8; i++) if (!an[i]) return i;
    return 0;
  endfunction

  function automatic logic [7:0] an_of(input int i);
    logic [7:0] one = 8'h01;
    return ~(one << i);
  endfunction

  function automatic logic [7:0] seg_of(input int i);
    logic [7:0] v = 8'h10 + 8'(i);
    return ~v;
  endfunction

  task automatic model_reset();
    last_in = 16'hFFFF;
    run = 1000;
    for (int i = 0; i < int'(DLY); i++) begin
      pipe[i].kind = 0; pipe[i].idx = 0; pipe[i].seg = 8'h00;
    end
    expect_idx = 0;
    idle = 0;
    for (int i = 0; i < 8; i++) begin seen[i] = 1'b0; m_frame[i] = 8'h00; end
    e_idx = 3'd0; e_valid = 0; e_done = 0; e_multi = 0; e_order = 0; e_tout = 0;
  endtask

  task automatic model_edge(input logic [7:0] an, input logic [7:0] seg);
    ev_t nw, due;
    bit  full;
    nw.kind = 0; nw.idx = 0; nw.seg = seg;
    if ({an, seg} == last_in) begin
      if (run < 1000) run++;
    end else begin
      run = 1;
    end
    last_in = {an, seg};
    if (run == int'(SETTLE) + 1) begin
      if (zero_count(an) == 1) begin nw.kind = 1; nw.idx = low_zero(an); end
      else if (zero_count(an) > 1) nw.kind = 2;
    end
    due = pipe[0];
    for (int i = 0; i < int'(DLY) - 1; i++) pipe[i] = pipe[i+1];
    pipe[DLY-1] = nw;

    e_valid = 0; e_done = 0; e_order = 0;
    e_multi = (due.kind == 2);
    if (due.kind == 1) begin
      e_valid = 1;
      e_idx = 3'(due.idx);
      m_frame[due.idx] = ~due.seg;
      idle = 0;
      e_tout = 0;
      full = 1'b1;
      for (int i = 0; i < 7; i++) full &= seen[i];
      if (due.idx != expect_idx) begin
        e_order = 1;
        for (int i = 0; i < 8; i++) seen[i] = (i == due.idx);
      end else if (due.idx == 7 && full) begin
        e_done = 1;
        for (int i = 0; i < 8; i++) seen[i] = 1'b0;
      end else begin
        seen[due.idx] = 1'b1;
      end
      expect_idx = (due.idx + 1) % 8;
    end else begin
      if (idle < int'(FT)) idle++;
      if (idle == int'(FT)) e_tout = 1;
    end
  endtask

  task automatic check_model(input string name);
    logic [63:0] ef;
    for (int i = 0; i < 8; i++) ef[8*i +: 8] = m_frame[i];
    compared++;
    if (digit_idx !== e_idx || digit_valid !== e_valid || frame_seg !== ef ||
        frame_done !== e_done || multi_err !== e_multi || order_err !== e_order ||
        timeout_err !== e_tout) begin
      mismatched++;
      $display("FAIL %s t=%0t got idx=%0d v=%b f=%h d=%b m=%b o=%b to=%b | want idx=%0d v=%b f=%h d=%b m=%b o=%b to=%b",
               name, $time, digit_idx, digit_valid, frame_seg, frame_done, multi_err, order_err, timeout_err,
               e_idx, e_valid, ef, e_done, e_multi, e_order, e_tout);
    end
  endtask

  task automatic step(input logic [7:0] an, input logic [7:0] seg, input string name);
    an_in  = an;
    seg_in = seg;
    @(posedge clk);
    model_edge(an, seg);
    #1;
    check_model(name);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    an_in  = 8'hFF;
    seg_in = 8'hFF;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    check_model("reset_state");
  endtask

  typedef struct {
    bit         rst;
    logic [7:0] an;
    logic [7:0] seg;
    int         hold;
    int         n_valid;
    int         idx;
    int         n_multi;
    int         n_order;
    int         n_done;
  } vec_t;

  vec_t tbl [$];

  task automatic add_vec(input bit rst, input logic [7:0] an, input logic [7:0] seg, input int hold,
                         input int nv, input int idx, input int nm, input int no, input int nd);
    vec_t v;
    v.rst = rst; v.an = an; v.seg = seg; v.hold = hold;
    v.n_valid = nv; v.idx = idx; v.n_multi = nm; v.n_order = no; v.n_done = nd;
    tbl.push_back(v);
  endtask

  initial begin
    int nv, gi, nm, no, nd;
    int first_to, v_step, t_step;
    int ptr;

    rst_n  = 1'b0;
    an_in  = 8'hFF;
    seg_in = 8'hFF;
    model_reset();

    // Clean scan 0..7 from reset.
    for (int i = 0; i < 8; i++)
      add_vec(i == 0, an_of(i), seg_of(i), 16, 1, i, 0, 0, (i == 7) ? 1 : 0);
    // Glitch filter, then multi-anode.
    add_vec(1, 8'hFB, 8'hA5, 2, 0, 0, 0, 0, 0);
    add_vec(0, 8'hF7, 8'h3C, 10, 1, 3, 0, 1, 0);
    add_vec(0, 8'hFC, 8'h00, 10, 0, 0, 1, 0, 0);
    // Order violation 0,1,2,5 then 6,7,0..7.
    add_vec(1, an_of(0), seg_of(0), 10, 1, 0, 0, 0, 0);
    add_vec(0, an_of(1), seg_of(1), 10, 1, 1, 0, 0, 0);
    add_vec(0, an_of(2), seg_of(2), 10, 1, 2, 0, 0, 0);
    add_vec(0, an_of(5), seg_of(5), 10, 1, 5, 0, 1, 0);
    add_vec(0, an_of(6), seg_of(6), 10, 1, 6, 0, 0, 0);
    add_vec(0, an_of(7), seg_of(7), 10, 1, 7, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add_vec(0, an_of(i), 8'(8'h40 + i), 10, 1, i, 0, 0, (i == 7) ? 1 : 0);

    foreach (tbl[k]) begin
      if (tbl[k].rst) do_reset();
      nv = 0; gi = 0; nm = 0; no = 0; nd = 0;
      for (int c = 0; c < tbl[k].hold; c++) begin
        step(tbl[k].an, tbl[k].seg, "vec_cycle");
        if (digit_valid) begin nv++; gi = int'(digit_idx); end
        if (multi_err)  nm++;
        if (order_err)  no++;
        if (frame_done) nd++;
      end
      compared++;
      if (nv != tbl[k].n_valid || gi != tbl[k].idx || nm != tbl[k].n_multi ||
          no != tbl[k].n_order || nd != tbl[k].n_done) begin
        mismatched++;
        $display("FAIL vec%0d got valid=%0d idx=%0d multi=%0d order=%0d done=%0d | want %0d %0d %0d %0d %0d",
                 k, nv, gi, nm, no, nd, tbl[k].n_valid, tbl[k].idx, tbl[k].n_multi,
                 tbl[k].n_order, tbl[k].n_done);
      end
    end

    // Blanking-only input times out exactly FT cycles after reset.
    do_reset();
    first_to = -1;
    for (int c = 1; c <= 150; c++) begin
      step(8'hFF, 8'hFF, "blank_cycle");
      if (timeout_err && first_to < 0) first_to = c;
    end
    compared++;
    if (first_to != int'(FT)) begin
      mismatched++;
      $display("FAIL timeout_from_reset got cycle=%0d want %0d", first_to, FT);
    end

    // A capture clears the timeout; it re-arms FT cycles after that capture.
    v_step = -1; t_step = -1;
    for (int c = 1; c <= 200; c++) begin
      step(an_of(0), seg_of(0), "timeout_hold");
      if (digit_valid && v_step < 0) begin
        v_step = c;
        compared++;
        if (timeout_err !== 1'b0) begin
          mismatched++;
          $display("FAIL timeout_clear got %b want 0", timeout_err);
        end
      end
      if (v_step > 0 && c > v_step && timeout_err && t_step < 0) t_step = c;
    end
    compared++;
    if (v_step < 0 || t_step - v_step != int'(FT)) begin
      mismatched++;
      $display("FAIL timeout_after_capture got gap=%0d (valid at %0d) want %0d", t_step - v_step, v_step, FT);
    end

    // Async reset mid-frame clears outputs without a clock edge.
    do_reset();
    for (int i = 0; i < 5; i++)
      for (int c = 0; c < 10; c++) step(an_of(i), seg_of(i), "midframe_scan");
    rst_n = 1'b0;
    #2;
    compared++;
    if ({digit_idx, digit_valid, frame_seg, frame_done, multi_err, order_err, timeout_err} !== '0) begin
      mismatched++;
      $display("FAIL async_reset got idx=%0d f=%h to=%b want all zero", digit_idx, frame_seg, timeout_err);
    end
    do_reset();
    nv = 0; no = 0;
    for (int c = 0; c < 10; c++) begin
      step(an_of(0), seg_of(0), "restart_cycle");
      if (digit_valid) nv++;
      if (order_err)   no++;
    end
    compared++;
    if (nv != 1 || no != 0) begin
      mismatched++;
      $display("FAIL restart_idx0 got valid=%0d order=%0d want 1 0", nv, no);
    end

    // Random scanning: mostly in-order digits, plus strays, blanks, multi and glitches.
    do_reset();
    ptr = 0;
    for (int n = 0; n < 300; n++) begin
      logic [7:0] an, seg;
      int r, hold, a, b;
      r    = int'($urandom_range(0, 9));
      hold = int'($urandom_range(5, 12));
      seg  = 8'($urandom);
      if (r <= 4) begin
        an = an_of(ptr); ptr = (ptr + 1) % 8;
      end else if (r == 5) begin
        an = an_of(int'($urandom_range(0, 7)));
      end else if (r == 6) begin
        an = 8'hFF;
      end else if (r == 7) begin
        a = int'($urandom_range(0, 7));
        b = (a + int'($urandom_range(1, 7))) % 8;
        an = an_of(a) & an_of(b);
      end else begin
        an = an_of(int'($urandom_range(0, 7)));
        hold = int'($urandom_range(1, 4));
      end
      for (int c = 0; c < hold; c++) step(an, seg, "random_cycle");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
